prog_freq_divider: RTL
======================

// Module: prog_freq_divider
// PURPOSE
//  Runtime-programmable successor to the fixed power-of-two clock divider.
//  - Divides in_clock by any integer N = div_in+1 (1..2^BITS).
//  - Divisor changes are glitch-free, applied only at period boundaries.
//  - Adds enable, synchronous restart, a one-cycle period tick and an exposed counter.
//  - out_clock is a registered divided clock/strobe for downstream slow logic;
//    it is not a clock-tree-quality clock.
// PARAMETERS
//  BITS         8           counter/divisor width; max period 2^BITS cycles
//  DEFAULT_DIV  2**BITS-1   active divisor after reset (N=2^BITS, matches fixed divider)
// PORTS
//  in_clock     in   1     clock; all logic on posedge
//  reset_n      in   1     asynchronous active-low reset
//  enable       in   1     1=count; 0=freeze counter/out_clock, tick=0
//  sync_clear   in   1     synchronous restart of the current period
//  div_in       in   BITS  new divisor code (period N = div_in+1)
//  div_load     in   1     one-cycle strobe; captures div_in into shadow register
//  load_pending out  1     shadow holds a divisor not yet applied
//  active_div   out  BITS  divisor code currently in use
//  counter      out  BITS  position in current period, 0..active_div
//  out_clock    out  1     divided clock
//  tick         out  1     1-cycle pulse on last cycle of each period
// BEHAVIOUR
//  Reset (async assert, sync release):
//   counter=0, out_clock=0, tick=0, active_div=DEFAULT_DIV, load_pending=0, shadow=DEFAULT_DIV.
//  Counting (enable=1): counter increments per edge; wraps active_div -> 0.
//  Let H = (active_div+1)>>1 = floor(N/2).
//   - out_clock=1 iff counter>=H; registered, aligned with counter in the same cycle.
//   - Low phase floor(N/2) cycles, high phase ceil(N/2); N=256: 128 low / 128 high.
//   - N=1 (active_div=0): counter stays 0, out_clock constant 1, tick every enabled cycle.
//  tick: combinational (enable && counter==active_div), asserted during the wrap cycle.
//  Divisor load:
//   - div_load=1: shadow<=div_in, load_pending<=1.
//   - Repeated loads before apply: last one wins.
//   - Apply point = wrap edge (tick=1): active_div<=shadow, counter<=0, load_pending<=0.
//   - div_load on the same cycle as a wrap: div_in is used directly at that wrap;
//     load_pending stays 0.
//   - Counter never exceeds the old divisor mid-period; shortening takes effect
//     only after the current period completes.
//  enable=0:
//   - counter and out_clock hold; tick=0.
//   - Any pending or simultaneous load applies at the next edge with counter<=0 and
//     out_clock<=(new H==0).
//  sync_clear=1:
//   - Next edge: counter=0, out_clock=(H==0), tick=0 that cycle; pending load applied.
//   - Overrides enable and wrap.
//  Priority: reset_n > sync_clear > enable=0 > normal counting.
//  Reset mid-period: immediate return to reset values; pending load discarded.
// TESTING
//  1 Defaults (half-period 10, reset released at t=18) ->
//    out_clock=1 at t=2560+k*5120 and 0 at t=5120+k*5120 for 64 periods; tick every 256 cycles.
//  2 div_load div_in=4 (N=5) mid-period -> load_pending=1 until wrap;
//    then out_clock pattern 0,0,1,1,1 repeating; tick every 5th cycle.
//  3 div_in=0 -> out_clock stuck 1, tick every cycle.
//    div_in=1 -> out_clock toggles every cycle.
//  4 Loads 9 then 2 before wrap -> active_div=2 after wrap.
//    Load coincident with tick -> applied that edge, load_pending never asserts.
//  5 enable=0 for 7 cycles at counter=100 -> counter held at 100, tick=0;
//    resume continues at 101.
//  6 sync_clear at counter=200 -> counter=0, out_clock=0 next cycle.
//    reset_n pulse mid-period with load pending -> active_div=255, load_pending=0.

Source files
------------

// File: rtl/prog_freq_divider.sv
// Runtime-programmable integer clock divider.
// Divides by N = active_div+1, with divisor changes taking effect only at period
// boundaries, restarts, or while the divider is paused.
module prog_freq_divider #(
  parameter int unsigned BITS        = 8,
  parameter int unsigned DEFAULT_DIV = (2 ** BITS) - 1
) (
  input  logic            in_clock_i,
  input  logic            reset_ni,
  input  logic            enable_i,
  input  logic            sync_clear_i,
  input  logic [BITS-1:0] div_in_i,
  input  logic            div_load_i,
  output logic            load_pending_o,
  output logic [BITS-1:0] active_div_o,
  output logic [BITS-1:0] counter_o,
  output logic            out_clock_o,
  output logic            tick_o
);

  localparam logic [BITS-1:0] DefDiv = BITS'(DEFAULT_DIV);

  logic [BITS-1:0] counter_q, counter_d;
  logic [BITS-1:0] active_div_q, active_div_d;
  logic [BITS-1:0] shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            out_clock_q, out_clock_d;

  logic            tick;
  logic            apply;
  logic [BITS-1:0] next_div;
  logic [BITS:0]   half;
  logic [BITS:0]   cnt_inc;

  // Period tick and divisor-apply decision.
  always_comb begin
    tick     = enable_i && !sync_clear_i && (counter_q == active_div_q);
    // A load arriving on the apply cycle bypasses the shadow register.
    next_div = div_load_i ? div_in_i : shadow_q;
    apply    = sync_clear_i || tick || (!enable_i && (pending_q || div_load_i));
    half     = ((BITS+1)'(active_div_q) + (BITS+1)'(1)) >> 1;
    cnt_inc  = (BITS+1)'(counter_q) + (BITS+1)'(1);
  end

  // Next-state: restart/apply, count, or hold; capture loads into the shadow.
  always_comb begin
    counter_d    = counter_q;
    active_div_d = active_div_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    out_clock_d  = out_clock_q;
    if (apply) begin
      active_div_d = next_div;
      shadow_d     = next_div;
      pending_d    = 1'b0;
      counter_d    = '0;
      // New period starts in the low phase unless N=1 (no low phase at all).
      out_clock_d  = (next_div == '0);
    end else begin
      if (enable_i) begin
        counter_d   = counter_q + BITS'(1);
        out_clock_d = (cnt_inc >= half);
      end
      if (div_load_i) begin
        shadow_d  = div_in_i;
        pending_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge in_clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      counter_q    <= '0;
      active_div_q <= DefDiv;
      shadow_q     <= DefDiv;
      pending_q    <= 1'b0;
      out_clock_q  <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      active_div_q <= active_div_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      out_clock_q  <= out_clock_d;
    end
  end

  assign load_pending_o = pending_q;
  assign active_div_o   = active_div_q;
  assign counter_o      = counter_q;
  assign out_clock_o    = out_clock_q;
  assign tick_o         = tick;

endmodule
